adc_chan_avg: RTL and testbench

- Downstream consumer of the ADC loop sequencer's sample stream.
- Each tagged 16-bit word carries the channel in [15:12] and the sample in [11:0]; it arrives with a one-cycle write strobe.
- The block keeps a separate accumulator per channel, averages 2^K samples, and pushes {chan, avg} into an output FIFO.
- The host/UART readout side drains the FIFO over a valid/ready handshake.

---
 rtl/adc_pkg.sv | 38 +++
 rtl/sync_fifo_fwft.sv | 63 ++++++
 rtl/adc_chan_avg.sv | 159 +++++++++++++++
 tb/tb_adc_chan_avg.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC sample path: tagged word layout and
// channel count, common to the loop sequencer and the channel averager.
package adc_pkg;

    localparam int CHAN_W   = 4;
    localparam int SAMPLE_W = 12;
    localparam int WORD_W   = 16;

    // Channels driven by the ADC loop sequencer.
    localparam int NCHAN    = 11;

    // Deepest averaging supported: 2^KMAX samples per output word.
    localparam int KMAX     = 7;

    // Width of the averaging-exponent input.
    localparam int K_W      = 3;

    // Word field positions.
    localparam int CHAN_MSB   = 15;
    localparam int CHAN_LSB   = 12;
    localparam int SAMPLE_MSB = 11;
    localparam int SAMPLE_LSB = 0;

    // Tagged word: channel in the top nibble, sample/average below.
    typedef struct packed {
        logic [CHAN_W-1:0]   chan;
        logic [SAMPLE_W-1:0] sample;
    } word_t;

    // Build a tagged word from a channel index and a 12-bit value.
    function automatic logic [WORD_W-1:0] pack_word(
        input logic [CHAN_W-1:0]   chan,
        input logic [SAMPLE_W-1:0] val
    );
        return {chan, val};
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO. Binary pointers carry one
// extra wrap bit so full and empty come straight from a pointer compare.
// A push while full is accepted only if a pop frees a slot in the same
// cycle; clr empties the FIFO and overrides any coincident push or pop.
module sync_fifo_fwft #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           din,
    input  logic                       pop,
    output logic [WIDTH-1:0]           dout,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = wptr - rptr;

    // Head word is visible combinationally; an empty FIFO presents zero.
    assign dout    = empty ? '0 : mem[rptr[AW-1:0]];

    // Read/write pointers; clr takes priority over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else if (clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (do_pop) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage array; contents past the pointers are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_push && !clr) begin
            mem[wptr[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/adc_chan_avg.sv
// Per-channel sample averager. Each tagged ADC word is added into its
// channel's accumulator; every 2^K samples the truncated mean is tagged
// with the channel and pushed into an output FWFT FIFO for the host side.
// K is captured from avg_log2 on clr and clamped to KMAX.
module adc_chan_avg #(
    parameter int NCHAN      = adc_pkg::NCHAN,
    parameter int KMAX       = adc_pkg::KMAX,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          clr,
    input  logic [2:0]                    avg_log2,
    input  logic [15:0]                   in_data,
    input  logic                          in_wren,
    output logic [15:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          ovf,
    output logic                          chan_err,
    output logic [$clog2(FIFO_DEPTH):0]   fill
);

    import adc_pkg::*;

    localparam int ACC_W = SAMPLE_W + KMAX;
    localparam int FAW   = $clog2(FIFO_DEPTH);

    // Truncating mean: divide the running total by 2^k and keep 12 bits.
    function automatic logic [SAMPLE_W-1:0] avg_trunc(
        input logic [ACC_W-1:0] total,
        input logic [2:0]       k
    );
        logic [ACC_W-1:0] shifted;
        shifted = total >> k;
        return shifted[SAMPLE_W-1:0];
    endfunction

    // Clamp the requested exponent to the deepest supported average.
    function automatic logic [2:0] clamp_k(input logic [2:0] k);
        if (int'(k) > KMAX) begin
            return 3'(KMAX);
        end
        return k;
    endfunction

    word_t              in_w;
    logic [ACC_W-1:0]   acc [NCHAN];
    logic [KMAX-1:0]    cnt [NCHAN];
    logic [2:0]         k_lat;

    logic               chan_ok;
    logic [ACC_W-1:0]   sel_acc;
    logic [KMAX-1:0]    sel_cnt;
    logic [KMAX-1:0]    cnt_last;
    logic [ACC_W-1:0]   sum;
    logic               wr_ok;
    logic               last_hit;
    logic               push;
    logic [WORD_W-1:0]  push_word;

    logic               fifo_empty;
    logic               fifo_full;
    logic               fifo_pop;
    logic [FAW:0]       fifo_count;

    assign in_w     = in_data;
    assign chan_ok  = ({1'b0, in_w.chan} < (CHAN_W+1)'(NCHAN));
    assign wr_ok    = in_wren & ~clr & chan_ok;

    // Last sample of a block arrives when the count reaches 2^K - 1; the
    // modular subtract keeps this correct even when 2^K overflows KMAX bits.
    assign cnt_last = (KMAX'(1) << k_lat) - KMAX'(1);
    assign last_hit = (sel_cnt == cnt_last);
    assign sum      = sel_acc + ACC_W'(in_w.sample);
    assign push     = wr_ok & last_hit;
    assign push_word = pack_word(in_w.chan, avg_trunc(sum, k_lat));

    // Select the addressed channel's accumulator and count.
    always_comb begin
        sel_acc = '0;
        sel_cnt = '0;
        for (int c = 0; c < NCHAN; c++) begin
            if (in_w.chan == CHAN_W'(c)) begin
                sel_acc = acc[c];
                sel_cnt = cnt[c];
            end
        end
    end

    // Accumulator bank and latched exponent; a completed block restarts its channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_lat <= '0;
            for (int c = 0; c < NCHAN; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else if (clr) begin
            k_lat <= clamp_k(avg_log2);
            for (int c = 0; c < NCHAN; c++) begin
                acc[c] <= '0;
                cnt[c] <= '0;
            end
        end else if (wr_ok) begin
            for (int c = 0; c < NCHAN; c++) begin
                if (in_w.chan == CHAN_W'(c)) begin
                    if (last_hit) begin
                        acc[c] <= '0;
                        cnt[c] <= '0;
                    end else begin
                        acc[c] <= sum;
                        cnt[c] <= sel_cnt + KMAX'(1);
                    end
                end
            end
        end
    end

    // Sticky error flags, cleared only by reset or clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            chan_err <= 1'b0;
        end else if (clr) begin
            ovf      <= 1'b0;
            chan_err <= 1'b0;
        end else begin
            if (push && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end
            if (in_wren && !chan_ok) begin
                chan_err <= 1'b1;
            end
        end
    end

    assign fifo_pop = out_ready & ~fifo_empty;

    sync_fifo_fwft #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .push  (push),
        .din   (push_word),
        .pop   (fifo_pop),
        .dout  (out_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign out_valid = ~fifo_empty;
    assign fill      = fifo_count;

endmodule

// File: tb/tb_adc_chan_avg.sv
// Bench for adc_chan_avg: directed scenarios plus randomized traffic, with
// a per-channel sum/count reference model feeding an expected-word queue
// and a separate monitor that pops and compares on every accepted output.
module tb_adc_chan_avg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic [2:0]  avg_log2 = 3'd0;
    logic [15:0] in_data = 16'h0;
    logic        in_wren = 1'b0;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        ovf;
    logic        chan_err;
    logic [4:0]  fill;

    always #5 clk = ~clk;

    adc_chan_avg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .avg_log2  (avg_log2),
        .in_data   (in_data),
        .in_wren   (in_wren),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ovf       (ovf),
        .chan_err  (chan_err),
        .fill      (fill)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic [15:0] exp_q[$];
    int          m_sum [11];
    int          m_n   [11];
    int          m_k = 0;
    bit          m_ovf = 0;
    bit          m_cerr = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int c = 0; c < 11; c++) begin
            m_sum[c] = 0;
            m_n[c]   = 0;
        end
        exp_q.delete();
    endtask

    // One clock of stimulus: first check state left by the previous edge,
    // then drive inputs for the next edge and advance the model.
    task automatic cyc(input bit wr, input logic [15:0] d, input bit rdy, input bit cl);
        int c;
        logic [15:0] w;
        @(posedge clk);
        #1;
        chk("fill", 32'(fill), 32'(exp_q.size()));
        chk("out_valid", 32'(out_valid), 32'(exp_q.size() != 0));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("chan_err", 32'(chan_err), 32'(m_cerr));
        if (exp_q.size() == 0) chk("out_data_empty", 32'(out_data), 32'h0);
        in_wren   = wr;
        in_data   = d;
        out_ready = rdy;
        clr       = cl;
        if (cl) begin
            model_clear();
            m_k    = (int'(avg_log2) > 7) ? 7 : int'(avg_log2);
            m_ovf  = 0;
            m_cerr = 0;
        end else if (wr) begin
            c = int'(d[15:12]);
            if (c >= 11) begin
                m_cerr = 1;
            end else begin
                m_sum[c] += int'(d[11:0]);
                m_n[c]   += 1;
                if (m_n[c] == (1 << m_k)) begin
                    w = {d[15:12], 12'(m_sum[c] / (1 << m_k))};
                    m_sum[c] = 0;
                    m_n[c]   = 0;
                    if (exp_q.size() >= 16 && !rdy) m_ovf = 1;
                    else exp_q.push_back(w);
                end
            end
        end
    endtask

    task automatic idle();
        cyc(1'b0, 16'h0, 1'b0, 1'b0);
    endtask

    task automatic do_clr(input logic [2:0] k);
        avg_log2 = k;
        cyc(1'b0, 16'h0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) cyc(1'b0, 16'h0, 1'b1, 1'b0);
        idle();
        chk("drain_empty", 32'(exp_q.size()), 32'h0);
    endtask

    // Monitor: each accepted output word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && !clr && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got %0h, expected no word at %0t", out_data, $time);
            end else begin
                if (out_data !== exp_q[0]) begin
                    errors++;
                    $display("FAIL pop_word: got %0h, expected %0h at %0t", out_data, exp_q[0], $time);
                end
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        model_clear();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_fill", 32'(fill), 32'h0);
        chk("rst_out_data", 32'(out_data), 32'h0);
        chk("rst_ovf", 32'(ovf), 32'h0);
        chk("rst_chan_err", 32'(chan_err), 32'h0);
        rst_n = 1'b1;

        // Pass-through
        do_clr(3'd0);
        cyc(1'b1, 16'h3ABC, 1'b0, 1'b0);
        idle();
        chk("pt_data", 32'(out_data), 32'h3ABC);
        chk("pt_fill", 32'(fill), 32'h1);
        chk("pt_valid", 32'(out_valid), 32'h1);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        idle();
        chk("pt_fill_after_pop", 32'(fill), 32'h0);
        chk("pt_valid_after_pop", 32'(out_valid), 32'h0);

        // Averaging with truncation, K=2
        do_clr(3'd2);
        cyc(1'b1, {4'd5, 12'd100}, 1'b0, 1'b0);
        cyc(1'b1, {4'd5, 12'd101}, 1'b0, 1'b0);
        cyc(1'b1, {4'd5, 12'd102}, 1'b0, 1'b0);
        cyc(1'b1, {4'd5, 12'd104}, 1'b0, 1'b0);
        chk("avg_no_early", 32'(fill), 32'h0);
        idle();
        chk("avg_word", 32'(out_data), 32'h5065);
        chk("avg_fill", 32'(fill), 32'h1);
        drain();

        // Channel interleave, K=1
        do_clr(3'd1);
        cyc(1'b1, {4'd0,  12'd10},   1'b0, 1'b0);
        cyc(1'b1, {4'd10, 12'd4095}, 1'b0, 1'b0);
        cyc(1'b1, {4'd0,  12'd20},   1'b0, 1'b0);
        cyc(1'b1, {4'd10, 12'd4095}, 1'b0, 1'b0);
        idle();
        chk("il_first", 32'(out_data), 32'h000F);
        chk("il_fill", 32'(fill), 32'h2);
        cyc(1'b0, 16'h0, 1'b1, 1'b0);
        idle();
        chk("il_second", 32'(out_data), 32'hAFFF);
        drain();

        // Overflow with the FIFO held full
        do_clr(3'd0);
        for (int i = 0; i < 17; i++) cyc(1'b1, {4'd1, 12'(i)}, 1'b0, 1'b0);
        idle();
        chk("ovf_fill", 32'(fill), 32'd16);
        chk("ovf_flag", 32'(ovf), 32'h1);
        cyc(1'b1, 16'h1777, 1'b1, 1'b0);
        idle();
        chk("full_pushpop_fill", 32'(fill), 32'd16);
        chk("full_pushpop_ovf", 32'(ovf), 32'h1);
        drain();

        // Bad channel
        cyc(1'b1, 16'hB123, 1'b0, 1'b0);
        idle();
        chk("bad_chan_err", 32'(chan_err), 32'h1);
        chk("bad_chan_fill", 32'(fill), 32'h0);
        do_clr(3'd0);
        idle();
        chk("bad_chan_cleared", 32'(chan_err), 32'h0);
        chk("ovf_cleared", 32'(ovf), 32'h0);

        // clr coincident with a strobe, K=3
        do_clr(3'd3);
        for (int i = 0; i < 5; i++) cyc(1'b1, {4'd2, 12'd4000}, 1'b0, 1'b0);
        cyc(1'b1, {4'd2, 12'd4000}, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) cyc(1'b1, {4'd2, 12'd800}, 1'b0, 1'b0);
        idle();
        chk("clr_mid_no_word", 32'(fill), 32'h0);
        cyc(1'b1, {4'd2, 12'd800}, 1'b0, 1'b0);
        idle();
        chk("clr_mid_fill", 32'(fill), 32'h1);
        chk("clr_mid_word", 32'(out_data), 32'h2320);
        drain();

        // Randomized traffic
        do_clr(3'($urandom_range(0, 3)));
        for (int i = 0; i < 1500; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 2) begin
                do_clr(3'($urandom_range(0, 7)));
            end else begin
                cyc(r < 70, {4'($urandom_range(0, 11)), 12'($urandom_range(0, 4095))},
                    ($urandom_range(0, 3) != 0), 1'b0);
            end
        end
        drain();

        // Asynchronous reset mid-run
        do_clr(3'd0);
        cyc(1'b1, 16'hB001, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, {4'd3, 12'(i + 5)}, 1'b0, 1'b0);
        idle();
        @(posedge clk);
        #3;
        rst_n     = 1'b0;
        in_wren   = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'h0);
        chk("arst_fill", 32'(fill), 32'h0);
        chk("arst_out_data", 32'(out_data), 32'h0);
        chk("arst_chan_err", 32'(chan_err), 32'h0);
        chk("arst_ovf", 32'(ovf), 32'h0);
        model_clear();
        m_k = 0;
        m_ovf = 0;
        m_cerr = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 16'h4555, 1'b0, 1'b0);
        idle();
        chk("post_rst_passthru", 32'(out_data), 32'h4555);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
